// File: rtl/uart_core_pkg.sv
// Shared types and helpers for the 8N1 console UART.
package uart_core_pkg;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  typedef enum logic {
    TxIdle,
    TxSend
  } tx_state_e;

  // Oversample tick divisor: clocks per 1/16 bit, truncated, never below 1.
  function automatic int unsigned calc_div(input int unsigned freq_hz, input int unsigned baud);
    int unsigned d;
    d = freq_hz / (16 * baud);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_baudgen.sv
// Free-running 16x oversample tick generator shared by the RX and TX paths.
module uart_baudgen #(
  parameter int unsigned div = 1
) (
  input  logic clk,
  input  logic reset,
  output logic ser_tick
);

  localparam int unsigned CntW = (div > 1) ? $clog2(div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(div - 1);

  logic [CntW-1:0] cnt;

  // Count 0..div-1 and emit a one-cycle tick on each wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      ser_tick <= 1'b0;
    end else if (cnt == CntMax) begin
      cnt      <= '0;
      ser_tick <= 1'b1;
    end else begin
      cnt      <= cnt + CntW'(1);
      ser_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_core.sv
// 8N1 UART: 16x oversampled receiver and independent transmitter, byte-wide parallel side.
module uart_core
  import uart_core_pkg::*;
#(
  parameter int unsigned freq_hz = 100000000,
  parameter int unsigned baud    = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic       uart_txd,
  output logic [7:0] rx_data,
  output logic       rx_avail,
  output logic       rx_error,
  input  logic       rx_ack,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_busy
);

  localparam int unsigned DIV = calc_div(freq_hz, baud);

  logic ser_tick;

  uart_baudgen #(
    .div(DIV)
  ) u_baudgen (
    .clk     (clk),
    .reset   (reset),
    .ser_tick(ser_tick)
  );

  // ---------------- receiver ----------------
  logic [1:0] rxd_sync;
  logic       rxd;
  rx_state_e  rx_state;
  logic [3:0] rx_tick_cnt;
  logic [2:0] rx_bit_cnt;
  logic [7:0] rx_shift;

  assign rxd = rxd_sync[1];

  // Two-flop synchroniser for the asynchronous line; resets to idle-high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rxd_sync <= 2'b11;
    else        rxd_sync <= {rxd_sync[0], uart_rxd};
  end

  // RX FSM: ack clears flags first so a completing frame in the same cycle wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state    <= RxIdle;
      rx_tick_cnt <= 4'd0;
      rx_bit_cnt  <= 3'd0;
      rx_shift    <= 8'h00;
      rx_data     <= 8'h00;
      rx_avail    <= 1'b0;
      rx_error    <= 1'b0;
    end else begin
      if (rx_ack) begin
        rx_avail <= 1'b0;
        rx_error <= 1'b0;
      end
      unique case (rx_state)
        RxIdle: begin
          if (!rxd) begin
            rx_state    <= RxStart;
            rx_tick_cnt <= 4'd0;
          end
        end
        RxStart: begin
          if (ser_tick) begin
            if (rx_tick_cnt == 4'd7) begin
              rx_tick_cnt <= 4'd0;
              rx_bit_cnt  <= 3'd0;
              // Still low at mid start bit: real frame; otherwise a glitch.
              rx_state    <= rxd ? RxIdle : RxData;
            end else begin
              rx_tick_cnt <= rx_tick_cnt + 4'd1;
            end
          end
        end
        RxData: begin
          if (ser_tick) begin
            if (rx_tick_cnt == 4'd15) begin
              rx_tick_cnt <= 4'd0;
              rx_shift    <= {rxd, rx_shift[7:1]};
              rx_bit_cnt  <= rx_bit_cnt + 3'd1;
              if (rx_bit_cnt == 3'd7) rx_state <= RxStop;
            end else begin
              rx_tick_cnt <= rx_tick_cnt + 4'd1;
            end
          end
        end
        RxStop: begin
          if (ser_tick) begin
            if (rx_tick_cnt == 4'd15) begin
              rx_tick_cnt <= 4'd0;
              rx_state    <= RxIdle;
              if (rxd) begin
                rx_data  <= rx_shift;
                rx_avail <= 1'b1;
                rx_error <= 1'b0;
              end else begin
                rx_error <= 1'b1;
              end
            end else begin
              rx_tick_cnt <= rx_tick_cnt + 4'd1;
            end
          end
        end
      endcase
    end
  end

  // ---------------- transmitter ----------------
  tx_state_e  tx_state;
  logic [9:0] tx_shift;
  logic [3:0] tx_tick_cnt;
  logic [3:0] tx_bit_cnt;

  // TX FSM: line driven from a register; busy drops the cycle after the stop bit ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state    <= TxIdle;
      tx_shift    <= 10'h3ff;
      tx_tick_cnt <= 4'd0;
      tx_bit_cnt  <= 4'd0;
      uart_txd    <= 1'b1;
      tx_busy     <= 1'b0;
    end else begin
      unique case (tx_state)
        TxIdle: begin
          uart_txd <= 1'b1;
          if (tx_wr) begin
            tx_shift    <= {1'b1, tx_data, 1'b0};
            tx_tick_cnt <= 4'd0;
            tx_bit_cnt  <= 4'd0;
            tx_busy     <= 1'b1;
            uart_txd    <= 1'b0;
            tx_state    <= TxSend;
          end
        end
        TxSend: begin
          if (ser_tick) begin
            if (tx_tick_cnt == 4'd15) begin
              tx_tick_cnt <= 4'd0;
              if (tx_bit_cnt == 4'd9) begin
                tx_busy  <= 1'b0;
                uart_txd <= 1'b1;
                tx_state <= TxIdle;
              end else begin
                tx_bit_cnt <= tx_bit_cnt + 4'd1;
                tx_shift   <= {1'b1, tx_shift[9:1]};
                uart_txd   <= tx_shift[1];
              end
            end else begin
              tx_tick_cnt <= tx_tick_cnt + 4'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench: two cross-wired uart_core instances plus a bit-banged line into the DUT RX.
module tb_uart_core;

  localparam int unsigned FreqHz = 50000000;
  localparam int unsigned Baud   = 1152000;
  localparam int BitClk = 32;
  localparam int Limit  = 2000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       d_txd, d_rxd, d_rx_avail, d_rx_error, d_rx_ack, d_tx_wr, d_tx_busy;
  logic [7:0] d_rx_data, d_tx_data;
  logic       p_txd, p_rx_avail, p_rx_error, p_rx_ack, p_tx_wr, p_tx_busy;
  logic [7:0] p_rx_data, p_tx_data;
  logic       bb_en, bb_line;

  assign d_rxd = bb_en ? bb_line : p_txd;

  uart_core #(.freq_hz(FreqHz), .baud(Baud)) u_dut (
    .clk(clk), .reset(reset), .uart_rxd(d_rxd), .uart_txd(d_txd),
    .rx_data(d_rx_data), .rx_avail(d_rx_avail), .rx_error(d_rx_error), .rx_ack(d_rx_ack),
    .tx_data(d_tx_data), .tx_wr(d_tx_wr), .tx_busy(d_tx_busy)
  );

  uart_core #(.freq_hz(FreqHz), .baud(Baud)) u_peer (
    .clk(clk), .reset(reset), .uart_rxd(d_txd), .uart_txd(p_txd),
    .rx_data(p_rx_data), .rx_avail(p_rx_avail), .rx_error(p_rx_error), .rx_ack(p_rx_ack),
    .tx_data(p_tx_data), .tx_wr(p_tx_wr), .tx_busy(p_tx_busy)
  );

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Busy cycles until the DUT transmitter drops tx_busy (bounded).
  task automatic wait_dut_idle(output int n);
    n = 0;
    while (d_tx_busy && n < Limit) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_peer_idle(output int n);
    n = 0;
    while (p_tx_busy && n < Limit) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Drive one frame onto the DUT RX line: start, b LSB first, given stop level.
  task automatic bit_bang(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      bb_line = frame[i];
      repeat (BitClk) @(negedge clk);
    end
    bb_line = 1'b1;
  endtask

  task automatic ack_both();
    d_rx_ack = 1'b1;
    p_rx_ack = 1'b1;
    @(negedge clk);
    d_rx_ack = 1'b0;
    p_rx_ack = 1'b0;
  endtask

  logic [7:0] seq [3];
  int n;
  int lows;

  initial begin
    seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'hA5;
    bb_en = 1'b0; bb_line = 1'b1;
    d_rx_ack = 1'b0; d_tx_wr = 1'b0; d_tx_data = 8'h00;
    p_rx_ack = 1'b0; p_tx_wr = 1'b0; p_tx_data = 8'h00;
    repeat (3) @(negedge clk);

    // reset state
    check_eq("rst_txd", d_txd, 1);
    check_eq("rst_busy", d_tx_busy, 0);
    check_eq("rst_avail", d_rx_avail, 0);
    check_eq("rst_error", d_rx_error, 0);
    check_eq("rst_data", d_rx_data, 8'h00);
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // 1: loopback both directions at once
    d_tx_data = 8'h55; d_tx_wr = 1'b1;
    p_tx_data = 8'h5A; p_tx_wr = 1'b1;
    @(negedge clk);
    d_tx_wr = 1'b0; p_tx_wr = 1'b0;
    check_eq("t1_busy_set", d_tx_busy, 1);
    wait_dut_idle(n);
    check_eq("t1_busy_len", (n >= 318 && n <= 322), 1);
    check_eq("t1_peer_data", p_rx_data, 8'h55);
    check_eq("t1_peer_avail", p_rx_avail, 1);
    check_eq("t1_peer_error", p_rx_error, 0);
    check_eq("t1_txd_idle", d_txd, 1);
    repeat (4) @(negedge clk);
    check_eq("t1_dut_data", d_rx_data, 8'h5A);
    check_eq("t1_dut_avail", d_rx_avail, 1);
    ack_both();
    check_eq("t1_peer_ack", p_rx_avail, 0);
    check_eq("t1_dut_ack", d_rx_avail, 0);

    // 2: back-to-back bytes, each written as busy falls
    for (int i = 0; i < 3; i++) begin
      d_tx_data = seq[i]; d_tx_wr = 1'b1;
      @(negedge clk);
      d_tx_wr = 1'b0;
      wait_dut_idle(n);
      check_eq($sformatf("t2_len%0d", i), (n >= 318 && n <= 322), 1);
      check_eq($sformatf("t2_data%0d", i), p_rx_data, seq[i]);
      check_eq($sformatf("t2_avail%0d", i), p_rx_avail, 1);
      check_eq($sformatf("t2_err%0d", i), p_rx_error, 0);
      ack_both();
    end

    // 3: framing error on bit-banged 8'h3C with stop low
    bb_en = 1'b1;
    repeat (BitClk) @(negedge clk);
    bit_bang(8'h3C, 1'b0);
    repeat (BitClk) @(negedge clk);
    check_eq("t3_error", d_rx_error, 1);
    check_eq("t3_avail", d_rx_avail, 0);
    check_eq("t3_data", d_rx_data, 8'h5A);
    ack_both();
    check_eq("t3_error_clr", d_rx_error, 0);

    // 4: short glitch rejected, then a valid 8'h81
    bb_line = 1'b0;
    repeat (4) @(negedge clk);
    bb_line = 1'b1;
    repeat (100) @(negedge clk);
    check_eq("t4_glitch_avail", d_rx_avail, 0);
    check_eq("t4_glitch_err", d_rx_error, 0);
    bit_bang(8'h81, 1'b1);
    repeat (4) @(negedge clk);
    check_eq("t4_data", d_rx_data, 8'h81);
    check_eq("t4_avail", d_rx_avail, 1);
    check_eq("t4_err", d_rx_error, 0);
    ack_both();
    bb_en = 1'b0;
    repeat (BitClk) @(negedge clk);

    // 5: overrun from peer, plus a write issued mid-frame that must be ignored
    p_tx_data = 8'h11; p_tx_wr = 1'b1;
    @(negedge clk);
    p_tx_wr = 1'b0;
    wait_peer_idle(n);
    p_tx_data = 8'h22; p_tx_wr = 1'b1;
    @(negedge clk);
    p_tx_wr = 1'b0;
    repeat (100) @(negedge clk);
    p_tx_data = 8'h77; p_tx_wr = 1'b1;
    @(negedge clk);
    p_tx_wr = 1'b0;
    wait_peer_idle(n);
    check_eq("t5_busy_len", (n + 101 >= 318 && n + 101 <= 322), 1);
    repeat (4) @(negedge clk);
    check_eq("t5_data", d_rx_data, 8'h22);
    check_eq("t5_avail", d_rx_avail, 1);
    check_eq("t5_err", d_rx_error, 0);
    lows = 0;
    for (int i = 0; i < 400; i++) begin
      if (!p_txd) lows++;
      @(negedge clk);
    end
    check_eq("t5_line_quiet", lows, 0);
    check_eq("t5_data_hold", d_rx_data, 8'h22);

    // 6: asynchronous reset mid-TX (0xF0 has d2 low at ~100 clk into frame)
    d_tx_data = 8'hF0; d_tx_wr = 1'b1;
    @(negedge clk);
    d_tx_wr = 1'b0;
    repeat (100) @(negedge clk);
    check_eq("t6_txd_low", d_txd, 0);
    check_eq("t6_busy_pre", d_tx_busy, 1);
    #2 reset = 1'b0;
    #1;
    check_eq("t6_txd_async", d_txd, 1);
    check_eq("t6_busy_async", d_tx_busy, 0);
    check_eq("t6_avail_async", d_rx_avail, 0);
    check_eq("t6_data_async", d_rx_data, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    repeat (400) @(negedge clk);
    check_eq("t6_txd_after", d_txd, 1);
    check_eq("t6_busy_after", d_tx_busy, 0);
    check_eq("t6_peer_avail", p_rx_avail, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
